// File: rtl/alu_div32.sv
// -----------------------------------------------------------------------------
// alu_div32 -- iterative 32-bit integer divider (DIV, DIVU, REM, REMU) with
// RISC-V M-extension semantics, plus its trial-subtraction adder.
//
// adder32 ports:
//   a_i, b_i   32-bit addends
//   ci_i       carry in
//   s_o        32-bit sum
//   co_o       carry out (1 means "no borrow" when used as a - b)
//
// alu_div32 ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous reset, active-high
//   start_i    request, sampled only while busy_o is low
//   op_i       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a_i, b_i   dividend / divisor, sampled with start_i
//   busy_o     high while an operation is in flight (CALC and FIX)
//   done_o     one-cycle pulse, result_o valid in this cycle
//   result_o   quotient or remainder, held until the next done_o
//
// Normal operations take 34 cycles (32 restoring steps, one sign fix-up,
// then done). Divide-by-zero and signed overflow finish in one cycle.
// -----------------------------------------------------------------------------

module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ci_i,
  output logic [31:0] s_o,
  output logic        co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, ci_i};

endmodule

module alu_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  logic [4:0]       cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rem_q;    // partial remainder
  logic [WIDTH-1:0] quo_q;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] div_q;    // divisor magnitude
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  // Request decode.
  logic             signed_op;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // One restoring step.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // Sign fix-up and result selection.
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] result_d;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // so no latch can be inferred.
  always_comb begin
    signed_op = ~op_i[0];
    div_zero  = (b_i == '0);
    overflow  = signed_op && (a_i == MIN_NEG) && (b_i == '1);
    a_mag     = (signed_op && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    b_mag     = (signed_op && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
  end

  // r' = {r, q[msb]} is 33 bits; r' >= d iff its top bit is set or the
  // 32-bit subtraction r'[31:0] - d produces a carry (no borrow).
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};

  adder32 u_sub (
    .a_i  (rem_shift[WIDTH-1:0]),
    .b_i  (~div_q),
    .ci_i (1'b1),
    .s_o  (diff),
    .co_o (carry)
  );

  always_comb begin
    no_borrow = rem_shift[WIDTH] | carry;
    rem_d     = no_borrow ? diff : rem_shift[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], no_borrow};
    quo_fix   = qneg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = rneg_q ? (~rem_q + 1'b1) : rem_q;
    result_d  = op_q[1] ? rem_fix : quo_fix;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        // DONE accepts a new request exactly like IDLE.
        S_IDLE, S_DONE: begin
          if (start_i) begin
            op_q <= op_i;
            if (div_zero) begin
              result_q <= op_i[1] ? a_i : '1;
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end else if (overflow) begin
              result_q <= op_i[1] ? '0 : MIN_NEG;
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              rem_q   <= '0;
              quo_q   <= a_mag;
              div_q   <= b_mag;
              qneg_q  <= signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              rneg_q  <= signed_op & a_i[WIDTH-1];
              cnt_q   <= '0;
              state_q <= S_CALC;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end

        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          result_q <= result_d;
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
